perm_job_sequencer: RTL

PERM_JOB_SEQUENCER -- requirements
Module: perm_job_sequencer

---
 rtl/perm_pkg.sv | 32 +++
 rtl/perm_rise_det.sv | 18 +
 rtl/perm_job_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/perm_pkg.sv
// Shared constants, FSM encoding and completion status codes for the permutation job sequencer.
package perm_pkg;

  localparam int LINE_W     = 25;
  localparam int N_LINES    = 64;
  localparam int CNT_OFFSET = 63;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CRST = 3'd1,
    GAP  = 3'd2,
    RUN  = 3'd3,
    FIN  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    STATUS_OK       = 2'b00,
    STATUS_SHORT    = 2'b01,
    STATUS_OVERRUN  = 2'b10,
    STATUS_TIMEOUT  = 2'b11
  } status_t;

  // Timeout outranks overrun, which outranks a short job.
  function automatic status_t job_status(input logic timed_out, input logic overrun,
                                         input logic full);
    if (timed_out) return STATUS_TIMEOUT;
    if (overrun)   return STATUS_OVERRUN;
    if (full)      return STATUS_OK;
    return STATUS_SHORT;
  endfunction

endpackage

// File: rtl/perm_rise_det.sv
// Registered rising-edge detector: the current level is compared against last cycle's level.
module perm_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_reg;

  always_ff @(posedge clk) begin
    if (rst) d_reg <= 1'b0;
    else     d_reg <= d;
  end

  assign rise = d & ~d_reg;

endmodule

// File: rtl/perm_job_sequencer.sv
// Sequences one permutation job: resets and starts the core, feeds input lines by core count,
// forwards output writes to the selected bank and reports completion status.
module perm_job_sequencer #(
  parameter int LINE_W     = perm_pkg::LINE_W,
  parameter int N_LINES    = perm_pkg::N_LINES,
  parameter int CNT_OFFSET = perm_pkg::CNT_OFFSET,
  parameter int RST_CYC    = 2,
  parameter int GAP_CYC    = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [1:0]        job_id,
  output logic [7:0]        rd_addr,
  input  logic [LINE_W-1:0] rd_data,
  output logic              core_rst,
  output logic              core_start,
  input  logic              core_done,
  input  logic [6:0]        core_cnt,
  output logic [LINE_W-1:0] core_line_in,
  input  logic              core_wr_en,
  input  logic [LINE_W-1:0] core_wr_val,
  output logic              out_valid,
  output logic [1:0]        out_bank,
  output logic [5:0]        out_line,
  output logic [LINE_W-1:0] out_data,
  output logic              job_done,
  output logic [1:0]        done_id,
  output logic [1:0]        done_status,
  output logic              busy
);

  import perm_pkg::*;

  localparam int PH_MAX = (RST_CYC > GAP_CYC) ? RST_CYC : GAP_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int RUN_W  = $clog2(TIMEOUT + 1);
  localparam int WR_W   = $clog2(N_LINES + 1);
  localparam logic [6:0] CNT_LO = 7'(CNT_OFFSET);
  localparam logic [6:0] CNT_HI = 7'(CNT_OFFSET + N_LINES - 1);

  state_t            state_reg, state_next;
  logic [1:0]        bank_reg, bank_next;
  logic [PH_W-1:0]   phase_cnt_reg, phase_cnt_next;
  logic [RUN_W-1:0]  run_cnt_reg, run_cnt_next;
  logic [WR_W-1:0]   wr_cnt_reg, wr_cnt_next;
  logic              overrun_reg, overrun_next;
  logic              timeout_reg, timeout_next;

  logic wr_rise, done_rise;
  logic ready_int, crst_int, start_int, valid_int, fin_int;
  logic in_range;
  logic [6:0] line_idx;

  perm_rise_det u_wr_det (
    .clk  (clk),
    .rst  (rst),
    .d    (core_wr_en),
    .rise (wr_rise)
  );

  perm_rise_det u_done_det (
    .clk  (clk),
    .rst  (rst),
    .d    (core_done),
    .rise (done_rise)
  );

  // Input line lookup follows the core's counter directly, outside the FSM.
  assign in_range     = (core_cnt >= CNT_LO) && (core_cnt <= CNT_HI);
  assign line_idx     = core_cnt - CNT_LO;
  assign rd_addr      = in_range ? {bank_reg, line_idx[5:0]} : {bank_reg, 6'd0};
  assign core_line_in = in_range ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bank_reg      <= 2'd0;
      phase_cnt_reg <= '0;
      run_cnt_reg   <= '0;
      wr_cnt_reg    <= '0;
      overrun_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bank_reg      <= bank_next;
      phase_cnt_reg <= phase_cnt_next;
      run_cnt_reg   <= run_cnt_next;
      wr_cnt_reg    <= wr_cnt_next;
      overrun_reg   <= overrun_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bank_next      = bank_reg;
    phase_cnt_next = phase_cnt_reg;
    run_cnt_next   = run_cnt_reg;
    wr_cnt_next    = wr_cnt_reg;
    overrun_next   = overrun_reg;
    timeout_next   = timeout_reg;
    ready_int      = 1'b0;
    crst_int       = 1'b0;
    start_int      = 1'b0;
    valid_int      = 1'b0;
    fin_int        = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_int = 1'b1;
        if (job_valid) begin
          bank_next      = job_id;
          phase_cnt_next = '0;
          run_cnt_next   = '0;
          wr_cnt_next    = '0;
          overrun_next   = 1'b0;
          timeout_next   = 1'b0;
          state_next     = CRST;
        end
      end
      CRST: begin
        crst_int = 1'b1;
        if (phase_cnt_reg == PH_W'(RST_CYC - 1)) begin
          phase_cnt_next = '0;
          state_next     = GAP;
        end else begin
          phase_cnt_next = phase_cnt_reg + PH_W'(1);
        end
      end
      GAP: begin
        if (phase_cnt_reg == PH_W'(GAP_CYC - 1)) begin
          run_cnt_next = '0;
          state_next   = RUN;
        end else begin
          phase_cnt_next = phase_cnt_reg + PH_W'(1);
        end
      end
      RUN: begin
        start_int    = 1'b1;
        run_cnt_next = run_cnt_reg + RUN_W'(1);
        // A write landing with the done edge is still counted before status is formed.
        if (wr_rise) begin
          if (wr_cnt_reg < WR_W'(N_LINES)) begin
            valid_int   = 1'b1;
            wr_cnt_next = wr_cnt_reg + WR_W'(1);
          end else begin
            overrun_next = 1'b1;
          end
        end
        if (run_cnt_reg == RUN_W'(TIMEOUT - 1)) begin
          timeout_next = 1'b1;
          state_next   = FIN;
        end else if (done_rise) begin
          state_next = FIN;
        end
      end
      FIN: begin
        fin_int    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign job_ready   = ready_int & ~rst;
  assign core_rst    = crst_int | rst;
  assign core_start  = start_int & ~rst;
  assign out_valid   = valid_int & ~rst;
  assign out_bank    = bank_reg;
  assign out_line    = rst ? 6'd0 : 6'(wr_cnt_reg);
  assign out_data    = core_wr_val;
  assign job_done    = fin_int & ~rst;
  assign done_id     = (fin_int & ~rst) ? bank_reg : 2'd0;
  assign done_status = (fin_int & ~rst)
                     ? job_status(timeout_reg, overrun_reg, wr_cnt_reg == WR_W'(N_LINES))
                     : 2'd0;
  assign busy        = (state_reg != IDLE) & ~rst;

endmodule
